// File: rtl/risc_v_id_stage.sv
// risc_v_id_stage
//   Instruction-decode stage of the pipelined RV32I core. Drives register
//   file read addresses straight from the IF/ID instruction, builds the
//   immediate, decodes control bits, detects load-use hazards, and owns the
//   ID/EX pipeline register (bubble insertion, flush, hold).
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   if_valid, if_instr, if_pc      IF/ID register contents
//   rf_read_addr1/2                combinational rs1/rs2 indices to the RF
//   rf_read_data1/2                combinational RF read data
//   flush                          kill the instruction entering ID/EX
//   ex_hold                        freeze ID/EX
//   stall_if                       freeze PC and IF/ID this cycle
//   id_ex_*                        registered ID/EX fields for EX

module risc_v_id_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] rf_read_addr1,
  output logic [ADDR_WIDTH-1:0] rf_read_addr2,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic [DATA_WIDTH-1:0] rf_read_data2,
  input  logic                  flush,
  input  logic                  ex_hold,
  output logic                  stall_if,
  output logic                  id_ex_valid,
  output logic [DATA_WIDTH-1:0] id_ex_pc,
  output logic [DATA_WIDTH-1:0] id_ex_rs1_data,
  output logic [DATA_WIDTH-1:0] id_ex_rs2_data,
  output logic [DATA_WIDTH-1:0] id_ex_imm,
  output logic [ADDR_WIDTH-1:0] id_ex_rs1,
  output logic [ADDR_WIDTH-1:0] id_ex_rs2,
  output logic [ADDR_WIDTH-1:0] id_ex_rd,
  output logic [6:0]            id_ex_opcode,
  output logic [2:0]            id_ex_funct3,
  output logic                  id_ex_funct7b5,
  output logic                  id_ex_reg_write,
  output logic                  id_ex_mem_read,
  output logic                  id_ex_mem_write
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } id_ex_t;

  id_ex_t id_ex_d, id_ex_q;

  logic [6:0]            opcode;
  logic [ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [31:0]           imm32;
  logic                  dec_reg_write, dec_mem_read, dec_mem_write;
  logic                  uses_rs1, uses_rs2;
  logic                  lu;

  assign opcode = if_instr[6:0];
  assign rs1    = ADDR_WIDTH'(if_instr[19:15]);
  assign rs2    = ADDR_WIDTH'(if_instr[24:20]);
  assign rd     = ADDR_WIDTH'(if_instr[11:7]);

  assign rf_read_addr1 = rs1;
  assign rf_read_addr2 = rs2;

  always_comb begin
    imm32         = '0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    case (opcode)
      OP_R: begin
        dec_reg_write = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_I_ALU, OP_JALR: begin
        imm32         = {{20{if_instr[31]}}, if_instr[31:20]};
        dec_reg_write = 1'b1;
        uses_rs1      = 1'b1;
      end
      OP_LOAD: begin
        imm32         = {{20{if_instr[31]}}, if_instr[31:20]};
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        uses_rs1      = 1'b1;
      end
      OP_STORE: begin
        imm32         = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        dec_mem_write = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        imm32    = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm32         = {if_instr[31:12], 12'b0};
        dec_reg_write = 1'b1;
      end
      OP_JAL: begin
        imm32         = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                         if_instr[20], if_instr[30:21], 1'b0};
        dec_reg_write = 1'b1;
      end
      default: ;
    endcase
    // Writes to x0 are architecturally discarded; dropping them here also
    // keeps the forwarding unit from matching on rd=0.
    if (rd == '0) dec_reg_write = 1'b0;
  end

  assign lu = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != '0) && if_valid &&
              ((uses_rs1 && (rs1 == id_ex_q.rd)) || (uses_rs2 && (rs2 == id_ex_q.rd)));

  assign stall_if = (lu | ex_hold) & ~flush;

  // Flush outranks hold: only valid/control are cleared, data fields keep
  // their old values since a dead slot's data is never consumed.
  always_comb begin
    id_ex_d = id_ex_q;
    if (flush) begin
      id_ex_d.valid     = 1'b0;
      id_ex_d.reg_write = 1'b0;
      id_ex_d.mem_read  = 1'b0;
      id_ex_d.mem_write = 1'b0;
    end else if (!ex_hold) begin
      id_ex_d.pc        = if_pc;
      id_ex_d.rs1_data  = rf_read_data1;
      id_ex_d.rs2_data  = rf_read_data2;
      id_ex_d.imm       = DATA_WIDTH'($signed(imm32));
      id_ex_d.rs1       = rs1;
      id_ex_d.rs2       = rs2;
      id_ex_d.rd        = rd;
      id_ex_d.opcode    = opcode;
      id_ex_d.funct3    = if_instr[14:12];
      id_ex_d.funct7b5  = if_instr[30];
      if (lu) begin
        id_ex_d.valid     = 1'b0;
        id_ex_d.reg_write = 1'b0;
        id_ex_d.mem_read  = 1'b0;
        id_ex_d.mem_write = 1'b0;
      end else begin
        id_ex_d.valid     = if_valid;
        id_ex_d.reg_write = dec_reg_write & if_valid;
        id_ex_d.mem_read  = dec_mem_read  & if_valid;
        id_ex_d.mem_write = dec_mem_write & if_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign id_ex_valid     = id_ex_q.valid;
  assign id_ex_pc        = id_ex_q.pc;
  assign id_ex_rs1_data  = id_ex_q.rs1_data;
  assign id_ex_rs2_data  = id_ex_q.rs2_data;
  assign id_ex_imm       = id_ex_q.imm;
  assign id_ex_rs1       = id_ex_q.rs1;
  assign id_ex_rs2       = id_ex_q.rs2;
  assign id_ex_rd        = id_ex_q.rd;
  assign id_ex_opcode    = id_ex_q.opcode;
  assign id_ex_funct3    = id_ex_q.funct3;
  assign id_ex_funct7b5  = id_ex_q.funct7b5;
  assign id_ex_reg_write = id_ex_q.reg_write;
  assign id_ex_mem_read  = id_ex_q.mem_read;
  assign id_ex_mem_write = id_ex_q.mem_write;

endmodule

// File: tb/tb_risc_v_id_stage.sv
// tb_risc_v_id_stage
//   Directed-vector bench for risc_v_id_stage: decode/immediates, load-use
//   stall and bubble, flush and hold priority, asynchronous reset.

module tb_risc_v_id_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [31:0] I_ADDI_NEG4 = 32'hFFC10093; // addi x1,x2,-4
  localparam logic [31:0] I_SW        = 32'h00512423; // sw x5,8(x2)
  localparam logic [31:0] I_BEQ_M16   = 32'hFE2088E3; // beq x1,x2,-16
  localparam logic [31:0] I_JAL_2048  = 32'h001000EF; // jal x1,+2048
  localparam logic [31:0] I_NOP       = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] I_BAD       = 32'hFFFFFFFF; // undefined opcode
  localparam logic [31:0] I_LUI       = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] I_LW_X3     = 32'h00022183; // lw x3,0(x4)
  localparam logic [31:0] I_LW_X0     = 32'h00022003; // lw x0,0(x4)
  localparam logic [31:0] I_ADD_X3    = 32'h006182B3; // add x5,x3,x6
  localparam logic [31:0] I_ADD_X0    = 32'h006002B3; // add x5,x0,x6
  localparam logic [31:0] I_ADDI_3    = 32'h00300293; // addi x5,x0,3

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [DW-1:0] if_pc;
  logic [AW-1:0] rf_read_addr1, rf_read_addr2;
  logic [DW-1:0] rf_read_data1, rf_read_data2;
  logic          flush, ex_hold, stall_if;
  logic          id_ex_valid;
  logic [DW-1:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [AW-1:0] id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [6:0]    id_ex_opcode;
  logic [2:0]    id_ex_funct3;
  logic          id_ex_funct7b5;
  logic          id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  risc_v_id_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .flush(flush), .ex_hold(ex_hold), .stall_if(stall_if),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_opcode(id_ex_opcode), .id_ex_funct3(id_ex_funct3),
    .id_ex_funct7b5(id_ex_funct7b5), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    rf_read_data1 = '0; rf_read_data2 = '0; flush = 1'b0; ex_hold = 1'b0;
    #2;
    check("rst_valid", id_ex_valid, 0);
    check("rst_stall", stall_if, 0);
    @(negedge clk); rst = 1'b0;
    tick;

    // addi x1,x2,-4
    drive(I_ADDI_NEG4, 32'h100); rf_read_data1 = 32'd7; rf_read_data2 = 32'd9;
    #1;
    check("rf_addr1", rf_read_addr1, 2);
    check("rf_addr2", rf_read_addr2, 28);
    tick;
    check("addi_valid", id_ex_valid, 1);
    check("addi_pc", id_ex_pc, 32'h100);
    check("addi_imm", id_ex_imm, 32'hFFFFFFFC);
    check("addi_rs1d", id_ex_rs1_data, 7);
    check("addi_rd", id_ex_rd, 1);
    check("addi_ctrl", {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write}, 3'b100);
    check("addi_opc", id_ex_opcode, 7'h13);

    drive(I_SW, 32'h104); tick;
    check("sw_imm", id_ex_imm, 8);
    check("sw_ctrl", {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write}, 3'b001);
    check("sw_rs2", id_ex_rs2, 5);
    check("sw_f3", id_ex_funct3, 3'b010);

    drive(I_BEQ_M16, 32'h108); tick;
    check("beq_imm", id_ex_imm, 32'hFFFFFFF0);
    check("beq_rw", id_ex_reg_write, 0);

    drive(I_JAL_2048, 32'h10C); tick;
    check("jal_imm", id_ex_imm, 32'h800);
    check("jal_rw", id_ex_reg_write, 1);

    drive(I_LUI, 32'h110); tick;
    check("lui_imm", id_ex_imm, 32'h12345000);

    drive(I_NOP, 32'h114); tick;
    check("nop_rw_x0", id_ex_reg_write, 0);

    drive(I_BAD, 32'h118); tick;
    check("bad_valid", id_ex_valid, 1);
    check("bad_imm", id_ex_imm, 0);
    check("bad_ctrl", {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write}, 3'b000);
    check("bad_f7b5", id_ex_funct7b5, 1);

    if_valid = 1'b0; if_instr = I_ADDI_NEG4; tick;
    check("inv_valid", id_ex_valid, 0);
    check("inv_rw", id_ex_reg_write, 0);

    // load-use: one-cycle stall, bubble, then the add
    drive(I_LW_X3, 32'h200); tick;
    check("lw_ctrl", {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write}, 3'b110);
    drive(I_ADD_X3, 32'h204); #1;
    check("lu_stall", stall_if, 1);
    tick;
    check("lu_bubble_v", id_ex_valid, 0);
    check("lu_bubble_mr", id_ex_mem_read, 0);
    check("lu_stall_off", stall_if, 0);
    tick;
    check("lu_add_v", id_ex_valid, 1);
    check("lu_add_rs1", id_ex_rs1, 3);
    check("lu_add_rd", id_ex_rd, 5);
    check("lu_add_pc", id_ex_pc, 32'h204);

    // no-stall cases
    drive(I_LW_X3, 32'h300); tick;
    drive(I_ADD_X0, 32'h304); #1;
    check("nolu_x0src", stall_if, 0);
    drive(I_ADDI_3, 32'h304); #1;
    check("nolu_unused_rs2", stall_if, 0);
    tick;
    drive(I_LW_X0, 32'h308); tick;
    drive(I_ADD_X0, 32'h30C); #1;
    check("nolu_lw_x0", stall_if, 0);
    tick;

    // flush coinciding with load-use
    drive(I_LW_X3, 32'h400); tick;
    drive(I_ADD_X3, 32'h404); flush = 1'b1; #1;
    check("fl_stall", stall_if, 0);
    tick;
    flush = 1'b0;
    check("fl_valid", id_ex_valid, 0);
    check("fl_ctrl", {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write}, 3'b000);

    // hold with a pending load-use: hold wins, load stays in ID/EX
    drive(I_LW_X3, 32'h500); rf_read_data1 = 32'h55; tick;
    drive(I_ADD_X3, 32'h504); rf_read_data1 = 32'h99; ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_stall", stall_if, 1);
      tick;
      check("hold_pc", id_ex_pc, 32'h500);
      check("hold_mr", id_ex_mem_read, 1);
      check("hold_rs1d", id_ex_rs1_data, 32'h55);
    end
    ex_hold = 1'b0; #1;
    check("post_hold_lu", stall_if, 1);
    tick;
    check("post_hold_bub", id_ex_valid, 0);
    tick;
    check("post_hold_add", id_ex_pc, 32'h504);

    // async reset mid-cycle while stalled
    drive(I_LW_X3, 32'h600); tick;
    drive(I_ADD_X3, 32'h604); #2;
    check("pre_rst_stall", stall_if, 1);
    rst = 1'b1; #1;
    check("arst_valid", id_ex_valid, 0);
    check("arst_pc", id_ex_pc, 0);
    check("arst_mr", id_ex_mem_read, 0);
    check("arst_rd", id_ex_rd, 0);
    check("arst_stall", stall_if, 0);
    ex_hold = 1'b1; #1;
    check("arst_hold_stall", stall_if, 1);
    ex_hold = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/risc_v_id_stage.md
# risc_v_id_stage

Instruction-decode stage of the pipelined RISC-V core, placed between the IF/ID register and the execute stage. It drives the register file read addresses from the fetched instruction, generates the immediate, decodes the per-instruction control bits, and detects load-use hazards. It owns the ID/EX pipeline register, with support for bubble insertion, flush and hold.

## Interface
- DATA_WIDTH, 32, datapath width
- ADDR_WIDTH, 5, register index width
- clk  in  1  rising-edge clock for the ID/EX register
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  IF/ID register holds a real instruction
- if_instr  in  32  instruction word from IF/ID
- if_pc  in  DATA_WIDTH  PC of if_instr
- rf_read_addr1 / rf_read_addr2  out  ADDR_WIDTH  combinational, if_instr[19:15] / [24:20]
- rf_read_data1 / rf_read_data2  in  DATA_WIDTH  register file read data, combinational
- flush  in  1  taken branch/jump resolved in EX; kill the instruction entering ID/EX
- ex_hold  in  1  EX cannot accept; freeze ID/EX
- stall_if  out  1  combinational; freeze PC and IF/ID this cycle
- id_ex_valid  out  1  ID/EX holds a real instruction
- id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  out  DATA_WIDTH  registered
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  ADDR_WIDTH  registered, used by the EX forwarding unit
- id_ex_opcode  out  7;  id_ex_funct3  out  3;  id_ex_funct7b5  out  1  registered
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write  out  1  registered

## Operation
- Decode follows the RV32I opcode classes.
  - R (0110011): reg_write; uses rs1 and rs2.
  - I-ALU (0010011), JALR (1100111): I-immediate; reg_write; uses rs1.
  - Load (0000011): I-immediate; reg_write and mem_read; uses rs1.
  - Store (0100011): S-immediate; mem_write; uses rs1 and rs2.
  - Branch (1100011): B-immediate; uses rs1 and rs2.
  - LUI/AUIPC (0110111/0010111): U-immediate; reg_write.
  - JAL (1101111): J-immediate; reg_write.
  - Any other opcode: imm=0 and all control bits 0, but the instruction still passes with valid=1.
- Immediates are sign-extended from instr[31]. B and J immediates have bit 0 equal to 0.
- reg_write is forced to 0 when rd=0.
- Load-use hazard (lu) is true when all of the following hold: id_ex_valid, id_ex_mem_read, id_ex_rd≠0, if_valid, and either (uses_rs1 and rs1=id_ex_rd) or (uses_rs2 and rs2=id_ex_rd).
- stall_if = (lu | ex_hold) & ~flush.
- ID/EX update at the rising edge, highest priority first:
  1. rst (async): clear ID/EX.
  2. flush: id_ex_valid←0, and all control bits←0.
  3. ex_hold: hold every ID/EX field.
  4. lu: insert a bubble (id_ex_valid←0, control bits←0). Data fields are don't-care.
  5. Otherwise: load the decoded fields, with id_ex_valid←if_valid and control bits ANDed with if_valid.
- Register file data is captured as-is. The register file writes on the falling edge, so a WB write in the same cycle is already visible and no WB forwarding is needed here.

## Timing
- Reset values: every id_ex_* output is 0, so id_ex_valid=0 and all control bits are 0.
- Reset is asynchronous: ID/EX clears immediately on rst rising, including mid-stall. During rst, stall_if follows its equation from the reset ID/EX contents and is therefore 0 unless ex_hold is 1.
- Latency: an instruction in IF/ID in cycle n appears on id_ex_* after the edge ending cycle n.
- A load-use stall lasts exactly one cycle. After the bubble, id_ex_mem_read=0, so lu deasserts.
- When ex_hold and lu are both true, the hold takes precedence. The load stays in ID/EX and stall_if stays 1.
- When flush and lu are both true, the flush wins, stall_if=0, and the IF stage reloads from the target.
- The rf_read_addr* outputs are purely combinational from if_instr, with no register.

## Test plan
- Reset: assert rst mid-cycle while id_ex_valid=1 -> all id_ex_* read 0 immediately, and stall_if=0 with ex_hold=0.
- Decode: if_instr=0xFFC10093 (addi x1,x2,-4) at pc 0x100, with rf_read_data1=7 -> next cycle id_ex_imm=0xFFFFFFFC, id_ex_rs1_data=7, id_ex_rd=1, reg_write=1, mem_read=0, mem_write=0.
- Immediates: sw x5,8(x2) (0x00512423) -> imm=8 and mem_write=1. beq with offset -16 -> imm=0xFFFFFFF0. jal x1,+2048 -> imm=0x800 and reg_write=1.
- Load-use: lw x3,0(x4) followed by add x5,x3,x6 -> stall_if=1 for one cycle, then a bubble in ID/EX (valid=0), then the add enters with id_ex_rs1=3. With add x5,x0,x6 instead, or lw x0 as the load -> no stall.
- Flush/hold: flush=1 coinciding with lu -> stall_if=0 and id_ex_valid=0 next cycle. ex_hold=1 for 3 cycles -> ID/EX contents unchanged and stall_if=1 throughout.
